// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, reset pc, load opcode and fetch word types for the pipeline front end
package pipe_pkg;
    localparam int DATA_W = 32;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC = 32'h1c00_0000;
    localparam logic [6:0] LOAD_OPC = 7'h03;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;
    typedef logic [DATA_W-1:0] inst_t;
    typedef struct packed {
        logic [PC_W-1:0] pc;
        inst_t data;
    } fetch_word_t;
endpackage

// File: rtl/pipe_sync_fifo.sv
// pipe_sync_fifo: first-word-fall-through register fifo with synchronous flush
module pipe_sync_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_pop;
    assign do_pop = pop & ~empty;
    assign empty = count == '0;
    assign rdata = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end
    overflow_chk: assert property (@(posedge clk) disable iff (rst || flush) !(push && count == CW'(DEPTH)));
endmodule

// File: rtl/pipe_fetch_src.sv
// pipe_fetch_src: sequential instruction fetch with buffering, valid/allowin handshake and redirect
module pipe_fetch_src
    import pipe_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              inst_req,
    output logic [PC_W-1:0]   inst_addr,
    input  logic [DATA_W-1:0] inst_rdata,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_is_load,
    input  logic              out_allowin
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = CW + 1;
    logic [PC_W-1:0] pc, req_pc;
    logic inflight, push, pop, empty;
    logic [CW-1:0] count;
    fetch_word_t wdata, rdata;
    assign inst_req = en & ~rst & ~redirect_valid & (({1'b0, count} + SW'(inflight)) < SW'(FIFO_DEPTH));
    assign inst_addr = pc;
    assign push = inflight & ~redirect_valid;
    assign pop = out_valid & out_allowin & ~redirect_valid;
    assign wdata = '{pc: req_pc, data: inst_rdata};
    assign out_valid = ~empty;
    assign out_data = rdata.data;
    assign out_pc = rdata.pc;
    assign out_is_load = out_valid & (rdata.data[6:0] == LOAD_OPC);
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            pc <= redirect_valid ? (redirect_pc & ~PC_W'(3)) : inst_req ? pc + PC_INC : pc;
            inflight <= inst_req;
        end
    end
    always_ff @(posedge clk) begin
        if (inst_req) req_pc <= pc;
    end
    pipe_sync_fifo #(
        .W($bits(fetch_word_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(redirect_valid),
        .push(push),
        .wdata(wdata),
        .pop(pop),
        .rdata(rdata),
        .empty(empty),
        .count(count)
    );
endmodule

// File: tb/tb_pipe_fetch_src.sv
// tb_pipe_fetch_src: scoreboard plus directed and table-driven checks for pipe_fetch_src
module tb_pipe_fetch_src;
    logic clk, rst, en, inst_req, redirect_valid, out_valid, out_is_load, out_allowin;
    logic [31:0] inst_addr, inst_rdata, redirect_pc, out_data, out_pc;
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } word_t;
    typedef struct {
        logic [31:0] rpc;
        logic [31:0] addr;
        logic ld0;
        logic ld1;
    } vec_t;
    word_t q[$];
    vec_t vt[4];
    bit pend;
    logic [31:0] ppc, mpc;
    pipe_fetch_src dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .inst_req(inst_req),
        .inst_addr(inst_addr),
        .inst_rdata(inst_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_pc(out_pc),
        .out_is_load(out_is_load),
        .out_allowin(out_allowin)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [31:0] memf(logic [31:0] a);
        return a == 32'h1c00_0200 ? 32'h0000_2003 :
               a == 32'h1c00_0204 ? 32'h0000_2013 :
               a == 32'h1c00_0300 ? 32'h0000_0083 :
               a == 32'h1c00_0304 ? 32'h0000_007f : a ^ 32'hA5A5_0000;
    endfunction
    always @(posedge clk) inst_rdata <= memf(inst_addr);
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        bit er;
        if (rst) begin
            q.delete();
            pend = 1'b0;
            mpc = 32'h1c00_0000;
        end else begin
            er = en && !redirect_valid && (q.size() + int'(pend) < 4);
            chk("sb_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("sb_pc", out_pc, q[0].pc);
                chk("sb_data", out_data, q[0].data);
            end
            chk("sb_load", 32'(out_is_load), 32'(q.size() != 0 ? q[0].data[6:0] == 7'h03 : 1'b0));
            chk("sb_req", 32'(inst_req), 32'(er));
            if (er) chk("sb_addr", inst_addr, mpc);
            if (redirect_valid) begin
                q.delete();
                pend = 1'b0;
                mpc = redirect_pc & ~32'h3;
            end else begin
                if (out_allowin && q.size() != 0) void'(q.pop_front());
                if (pend) q.push_back('{ppc, memf(ppc)});
                pend = er;
                ppc = mpc;
                if (er) mpc = mpc + 32'd4;
            end
        end
    end
    task automatic adv();
        @(posedge clk);
        #1;
    endtask
    task automatic at_neg();
        @(negedge clk);
    endtask
    initial begin
        vt[0] = '{32'h1c00_0103, 32'h1c00_0100, 1'b0, 1'b0};
        vt[1] = '{32'h1c00_0201, 32'h1c00_0200, 1'b1, 1'b0};
        vt[2] = '{32'h1c00_0302, 32'h1c00_0300, 1'b1, 1'b0};
        vt[3] = '{32'hffff_fffe, 32'hffff_fffc, 1'b0, 1'b0};
        rst = 1'b1;
        en = 1'b0;
        out_allowin = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        adv();
        adv();
        at_neg();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_req", 32'(inst_req), 0);
        chk("rst_load", 32'(out_is_load), 0);
        adv();
        rst = 1'b0;
        en = 1'b1;
        out_allowin = 1'b1;
        at_neg();
        chk("first_req", 32'(inst_req), 1);
        chk("first_addr", inst_addr, 32'h1c00_0000);
        chk("first_valid0", 32'(out_valid), 0);
        adv();
        at_neg();
        chk("lat_valid0", 32'(out_valid), 0);
        chk("second_addr", inst_addr, 32'h1c00_0004);
        adv();
        at_neg();
        chk("lat_valid1", 32'(out_valid), 1);
        chk("lat_pc", out_pc, 32'h1c00_0000);
        adv();
        at_neg();
        chk("stream_pc", out_pc, 32'h1c00_0004);
        adv();
        repeat (4) adv();
        out_allowin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            chk("stall_pc", out_pc, 32'h1c00_0018);
            chk("stall_data", out_data, 32'hb9a5_0018);
            adv();
        end
        chk("full_req", 32'(inst_req), 0);
        out_allowin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            at_neg();
            chk("release_valid", 32'(out_valid), 1);
            chk("release_pc", out_pc, 32'h1c00_0018 + 32'(4 * i));
            adv();
        end
        out_allowin = 1'b0;
        repeat (6) adv();
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_0103;
        out_allowin = 1'b1;
        at_neg();
        chk("redir_full_req", 32'(inst_req), 0);
        adv();
        redirect_valid = 1'b0;
        at_neg();
        chk("redir_full_valid", 32'(out_valid), 0);
        chk("redir_full_addr", inst_addr, 32'h1c00_0100);
        adv();
        at_neg();
        chk("redir_full_valid2", 32'(out_valid), 0);
        adv();
        at_neg();
        chk("redir_full_pc", out_pc, 32'h1c00_0100);
        chk("redir_full_data", out_data, 32'hb9a5_0100);
        adv();
        for (int i = 0; i < 4; i++) begin
            redirect_valid = 1'b1;
            redirect_pc = vt[i].rpc;
            at_neg();
            chk("vec_r_req", 32'(inst_req), 0);
            adv();
            redirect_valid = 1'b0;
            at_neg();
            chk("vec_valid0", 32'(out_valid), 0);
            chk("vec_req", 32'(inst_req), 1);
            chk("vec_addr", inst_addr, vt[i].addr);
            adv();
            at_neg();
            chk("vec_valid1", 32'(out_valid), 0);
            adv();
            at_neg();
            chk("vec_valid2", 32'(out_valid), 1);
            chk("vec_pc0", out_pc, vt[i].addr);
            chk("vec_ld0", 32'(out_is_load), 32'(vt[i].ld0));
            adv();
            at_neg();
            chk("vec_pc1", out_pc, vt[i].addr + 32'd4);
            chk("vec_ld1", 32'(out_is_load), 32'(vt[i].ld1));
            adv();
            adv();
            adv();
        end
        out_allowin = 1'b0;
        adv();
        adv();
        rst = 1'b1;
        at_neg();
        chk("mid_rst_valid_before", 32'(out_valid), 1);
        chk("mid_rst_req", 32'(inst_req), 0);
        adv();
        at_neg();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_req2", 32'(inst_req), 0);
        adv();
        rst = 1'b0;
        out_allowin = 1'b1;
        at_neg();
        chk("post_rst_req", 32'(inst_req), 1);
        chk("post_rst_addr", inst_addr, 32'h1c00_0000);
        chk("post_rst_valid", 32'(out_valid), 0);
        adv();
        en = 1'b0;
        at_neg();
        chk("en_off_req", 32'(inst_req), 0);
        chk("en_off_valid0", 32'(out_valid), 0);
        adv();
        at_neg();
        chk("en_off_valid1", 32'(out_valid), 1);
        chk("en_off_pc", out_pc, 32'h1c00_0000);
        chk("en_off_data", out_data, 32'hb9a5_0000);
        adv();
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("drain_valid", 32'(out_valid), 0);
            chk("drain_req", 32'(inst_req), 0);
            adv();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
